// File: rtl/uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// uart_tx_scheduler
//
// Shares one 8-bit UART transmit AXI-stream between two requesters:
//   - a 48-bit accelerometer sample stream. Each sample goes out as an
//     8-byte frame: header, six sample bytes (least significant first),
//     then an XOR checksum of the six sample bytes.
//   - an 8-bit echo byte stream. A grant sends bursts of up to
//     MAX_ECHO_BURST bytes back-to-back.
// Arbitration is round-robin and happens only in IDLE, so a frame or burst
// is never split or interleaved. IDLE always lasts at least one cycle
// between packets.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-low reset
//   s_accel_tdata  accelerometer sample (48 bits)
//   s_accel_tvalid sample valid
//   s_accel_tready sample accepted (IDLE only, when accel holds the grant)
//   s_echo_tdata   echo byte
//   s_echo_tvalid  echo byte valid
//   s_echo_tready  echo byte accepted
//   m_tdata        byte to the UART transmitter
//   m_tvalid       byte valid
//   m_tready       UART transmitter ready
//   busy           high whenever a frame or burst is in progress
//   frame_count    number of completed accel frames, wraps
// ---------------------------------------------------------------------------
module uart_tx_scheduler #(
    parameter logic [7:0]  HEADER_BYTE    = 8'hA5,
    parameter int unsigned MAX_ECHO_BURST = 4,
    parameter int unsigned COUNT_WIDTH    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [47:0]            s_accel_tdata,
    input  logic                   s_accel_tvalid,
    output logic                   s_accel_tready,
    input  logic [7:0]             s_echo_tdata,
    input  logic                   s_echo_tvalid,
    output logic                   s_echo_tready,
    output logic [7:0]             m_tdata,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] frame_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCEL = 2'd1,
        ECHO  = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_ACCEL = 1'b0,
        GRANT_ECHO  = 1'b1
    } grant_t;

    localparam logic [7:0] MAX_BURST = 8'(MAX_ECHO_BURST);
    localparam logic [2:0] LAST_IDX  = 3'd7;

    state_t      state;
    state_t      state_next;
    grant_t      last_grant;

    logic        grant_accel;
    logic        grant_echo;
    logic        accel_hs;
    logic        echo_hs;
    logic        m_hs;

    logic [47:0] sample;
    logic [2:0]  idx;
    logic [2:0]  idx_next;
    logic [7:0]  burst;
    logic [7:0]  checksum;
    logic [7:0]  next_accel_byte;

    // -----------------------------------------------------------------------
    // Round-robin grant, only meaningful in IDLE. With both requesters
    // valid the one that did not go last wins; last_grant resets to ECHO
    // so accel wins the first tie.
    // -----------------------------------------------------------------------
    assign grant_accel = s_accel_tvalid &&
                         (!s_echo_tvalid || (last_grant == GRANT_ECHO));
    assign grant_echo  = s_echo_tvalid &&
                         (!s_accel_tvalid || (last_grant == GRANT_ACCEL));

    assign accel_hs = s_accel_tvalid && s_accel_tready;
    assign echo_hs  = s_echo_tvalid  && s_echo_tready;
    assign m_hs     = m_tvalid && m_tready;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // in the design samples pre-edge values, independent of block order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    // NOTE: the default assignment up front keeps every path assigned, so no
    // latch is inferred when a case arm leaves the state unchanged.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accel_hs) begin
                    state_next = ACCEL;
                end else if (echo_hs) begin
                    state_next = ECHO;
                end
            end
            ACCEL: begin
                if (m_hs && (idx == LAST_IDX)) begin
                    state_next = IDLE;
                end
            end
            ECHO: begin
                // A handshake without a replacement byte ends the burst.
                if (m_hs && !echo_hs) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // Outside IDLE a byte is always pending on m, so m_tvalid follows the
    // state directly. Readies are held low during reset so no source sees a
    // handshake that the scheduler then discards.
    // In ECHO the next echo byte is taken on the same edge as the current
    // byte's handshake, which gives one byte per cycle with no bubble.
    // -----------------------------------------------------------------------
    always_comb begin
        m_tvalid       = 1'b0;
        busy           = 1'b0;
        s_accel_tready = 1'b0;
        s_echo_tready  = 1'b0;
        unique case (state)
            IDLE: begin
                s_accel_tready = reset && grant_accel;
                s_echo_tready  = reset && grant_echo;
            end
            ACCEL: begin
                m_tvalid = 1'b1;
                busy     = 1'b1;
            end
            ECHO: begin
                m_tvalid      = 1'b1;
                busy          = 1'b1;
                s_echo_tready = reset && m_tready && (burst < MAX_BURST);
            end
            default: begin
                m_tvalid = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Accel frame byte selection. idx names the byte currently on m, so the
    // byte to load on its handshake is idx+1.
    // -----------------------------------------------------------------------
    assign idx_next = idx + 3'd1;
    assign checksum = sample[7:0]   ^ sample[15:8]  ^ sample[23:16] ^
                      sample[31:24] ^ sample[39:32] ^ sample[47:40];

    always_comb begin
        next_accel_byte = HEADER_BYTE;
        unique case (idx_next)
            3'd1:    next_accel_byte = sample[7:0];
            3'd2:    next_accel_byte = sample[15:8];
            3'd3:    next_accel_byte = sample[23:16];
            3'd4:    next_accel_byte = sample[31:24];
            3'd5:    next_accel_byte = sample[39:32];
            3'd6:    next_accel_byte = sample[47:40];
            3'd7:    next_accel_byte = checksum;
            default: next_accel_byte = HEADER_BYTE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Payload registers: latched sample, byte index and burst length.
    // NOTE: these carry no reset; they are always written before they are
    // read (on the grant that enters ACCEL/ECHO), and leaving them out of
    // reset keeps the reset net off a 48-bit data register.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accel_hs) begin
            sample <= s_accel_tdata;
            idx    <= 3'd0;
        end else if ((state == ACCEL) && m_hs) begin
            idx <= idx_next;
        end

        if (echo_hs) begin
            burst <= (state == IDLE) ? 8'd1 : burst + 8'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Output byte, frame counter and round-robin history.
    // m_tdata only changes on a grant or on an m handshake, which keeps it
    // stable while the UART applies backpressure.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            m_tdata     <= 8'h00;
            frame_count <= '0;
            last_grant  <= GRANT_ECHO;
        end else begin
            if (accel_hs) begin
                m_tdata    <= HEADER_BYTE;
                last_grant <= GRANT_ACCEL;
            end else if (echo_hs) begin
                m_tdata    <= s_echo_tdata;
                last_grant <= GRANT_ECHO;
            end else if ((state == ACCEL) && m_hs) begin
                if (idx == LAST_IDX) begin
                    frame_count <= frame_count + 1'b1;
                end else begin
                    m_tdata <= next_accel_byte;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_scheduler
//
// Directed bench for uart_tx_scheduler (frame counter narrowed to 4 bits so
// the wrap is reachable quickly). A posedge monitor records every m
// handshake with its cycle number, counts source handshakes and flags any
// change of m_tdata while the UART holds it off. Inputs are driven on the
// falling edge; expected byte streams are written out by hand.
// ---------------------------------------------------------------------------
module tb_uart_tx_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [47:0] s_accel_tdata;
    logic        s_accel_tvalid;
    logic        s_accel_tready;
    logic [7:0]  s_echo_tdata;
    logic        s_echo_tvalid;
    logic        s_echo_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        busy;
    logic [3:0]  frame_count;

    always #5 clk = ~clk;

    uart_tx_scheduler #(
        .HEADER_BYTE   (8'hA5),
        .MAX_ECHO_BURST(4),
        .COUNT_WIDTH   (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .s_accel_tdata (s_accel_tdata),
        .s_accel_tvalid(s_accel_tvalid),
        .s_accel_tready(s_accel_tready),
        .s_echo_tdata  (s_echo_tdata),
        .s_echo_tvalid (s_echo_tvalid),
        .s_echo_tready (s_echo_tready),
        .m_tdata       (m_tdata),
        .m_tvalid      (m_tvalid),
        .m_tready      (m_tready),
        .busy          (busy),
        .frame_count   (frame_count)
    );

    // Sample 0x0123_4567_89AB: A5, AB,89,67,45,23,01, checksum 22.
    localparam logic [47:0] SAMPLE_A = 48'h0123_4567_89AB;
    localparam logic [63:0] FRAME_A  = 64'hA5AB_8967_4523_0122;
    // Sample 0x1122_3344_5566: A5, 66,55,44,33,22,11, checksum 77.
    localparam logic [47:0] SAMPLE_B = 48'h1122_3344_5566;
    localparam logic [63:0] FRAME_B  = 64'hA566_5544_3322_1177;

    int n_cmp = 0;
    int n_err = 0;

    int         cyc = 0;
    logic [7:0] rx_q[$];
    int         rx_cyc[$];
    int         accel_acc = 0;
    int         echo_acc  = 0;
    int         stab_err  = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            if (m_tvalid && m_tready) begin
                rx_q.push_back(m_tdata);
                rx_cyc.push_back(cyc);
            end
            if (s_accel_tvalid && s_accel_tready) accel_acc <= accel_acc + 1;
            if (s_echo_tvalid && s_echo_tready)   echo_acc  <= echo_acc + 1;
            if (prev_stall && (!m_tvalid || (m_tdata != prev_data)))
                stab_err <= stab_err + 1;
            prev_stall <= m_tvalid && !m_tready;
            prev_data  <= m_tdata;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] byte_at(input int i);
        return (i < rx_q.size()) ? rx_q[i] : 8'hxx;
    endfunction

    function automatic int cyc_at(input int i);
        return (i < rx_cyc.size()) ? rx_cyc[i] : -1000;
    endfunction

    task automatic clear_q();
        rx_q.delete();
        rx_cyc.delete();
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int b = 0;
        while ((rx_q.size() < n) && (b < budget)) begin
            @(negedge clk);
            b++;
        end
        if (rx_q.size() < n) check("byte_timeout", 64'(rx_q.size()), 64'(n));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Offers one sample and returns on the falling edge after acceptance,
    // then scrambles tdata to show mid-frame changes are ignored.
    task automatic send_accel(input logic [47:0] d);
        int base = accel_acc;
        int b    = 0;
        @(negedge clk);
        s_accel_tdata  = d;
        s_accel_tvalid = 1'b1;
        while ((accel_acc == base) && (b < 50)) begin
            @(negedge clk);
            b++;
        end
        if (accel_acc == base) check("accel_accept_timeout", 64'd0, 64'd1);
        s_accel_tvalid = 1'b0;
        s_accel_tdata  = ~d;
    endtask

    task automatic check_frame(input string tag, input int off,
                               input logic [63:0] exp);
        for (int i = 0; i < 8; i++)
            check($sformatf("%s_b%0d", tag, i), 64'(byte_at(off + i)),
                  64'(exp[63-8*i -: 8]));
    endtask

    initial begin
        int base;
        int b;
        reset          = 1'b0;
        s_accel_tdata  = '0;
        s_accel_tvalid = 1'b0;
        s_echo_tdata   = '0;
        s_echo_tvalid  = 1'b0;
        m_tready       = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_m_tdata", 64'(m_tdata), 64'h00);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_frame_count", 64'(frame_count), 64'd0);
        check("rst_accel_tready", 64'(s_accel_tready), 64'd0);
        reset = 1'b1;

        // Single frame at full rate
        clear_q();
        send_accel(SAMPLE_A);
        wait_bytes(8, 40);
        check_frame("single", 0, FRAME_A);
        check("single_span", 64'(cyc_at(7) - cyc_at(0)), 64'd7);
        check("single_frame_count", 64'(frame_count), 64'd1);
        check("single_accel_pulses", 64'(accel_acc), 64'd1);
        check("single_busy_after", 64'(busy), 64'd0);
        check("single_tvalid_after", 64'(m_tvalid), 64'd0);

        // Same frame under random backpressure
        clear_q();
        m_tready = 1'b0;
        send_accel(SAMPLE_A);
        b = 0;
        while ((rx_q.size() < 8) && (b < 300)) begin
            m_tready = 1'($urandom_range(0, 1));
            @(negedge clk);
            b++;
        end
        m_tready = 1'b1;
        wait_bytes(8, 20);
        check_frame("bp", 0, FRAME_A);
        check("bp_stable", 64'(stab_err), 64'd0);
        check("bp_frame_count", 64'(frame_count), 64'd2);

        // Echo burst of six bytes with a burst limit of four
        clear_q();
        base = echo_acc;
        b    = 0;
        while (((echo_acc - base) < 6) && (b < 100)) begin
            s_echo_tdata  = 8'h30 + 8'(echo_acc - base);
            s_echo_tvalid = 1'b1;
            @(negedge clk);
            b++;
        end
        s_echo_tvalid = 1'b0;
        wait_bytes(6, 20);
        for (int i = 0; i < 6; i++)
            check($sformatf("echo_b%0d", i), 64'(byte_at(i)), 64'(8'h30 + i));
        check("echo_first_run", 64'(cyc_at(3) - cyc_at(0)), 64'd3);
        check("echo_gap", 64'(cyc_at(4) - cyc_at(3)), 64'd2);
        check("echo_second_run", 64'(cyc_at(5) - cyc_at(4)), 64'd1);

        // Contention from reset: accel first, then alternating
        do_reset();
        clear_q();
        base           = echo_acc;
        b              = 0;
        s_accel_tdata  = SAMPLE_A;
        s_accel_tvalid = 1'b1;
        while ((rx_q.size() < 24) && (b < 200)) begin
            s_echo_tdata  = 8'h40 + 8'(echo_acc - base);
            s_echo_tvalid = 1'b1;
            @(negedge clk);
            b++;
        end
        s_accel_tvalid = 1'b0;
        s_echo_tvalid  = 1'b0;
        wait_bytes(24, 10);
        check_frame("cont_f0", 0, FRAME_A);
        for (int i = 0; i < 4; i++)
            check($sformatf("cont_e0_b%0d", i), 64'(byte_at(8 + i)), 64'(8'h40 + i));
        check_frame("cont_f1", 12, FRAME_A);
        for (int i = 0; i < 4; i++)
            check($sformatf("cont_e1_b%0d", i), 64'(byte_at(20 + i)), 64'(8'h44 + i));
        check("cont_frame_count", 64'(frame_count), 64'd2);

        // Reset after the third byte of a frame
        @(negedge clk);
        clear_q();
        send_accel(SAMPLE_A);
        wait_bytes(3, 20);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_frame_count", 64'(frame_count), 64'd0);
        reset = 1'b1;
        clear_q();
        send_accel(SAMPLE_B);
        wait_bytes(8, 40);
        check_frame("post_rst", 0, FRAME_B);
        check("post_rst_frame_count", 64'(frame_count), 64'd1);

        // Frame counter wrap with a 4-bit counter
        do_reset();
        check("wrap_start", 64'(frame_count), 64'd0);
        for (int k = 1; k <= 17; k++) begin
            clear_q();
            send_accel(SAMPLE_A);
            wait_bytes(8, 40);
            if (k == 15) check("wrap_15", 64'(frame_count), 64'd15);
            if (k == 16) check("wrap_16", 64'(frame_count), 64'd0);
        end
        check_frame("wrap_last", 0, FRAME_A);
        check("wrap_17", 64'(frame_count), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
